// File: rtl/and3_arbiter.sv
// -----------------------------------------------------------------------------
// and3_arbiter
//   Shares a single 3-input AND unit between NREQ requesters using a
//   round-robin grant. A grant is issued combinationally when the response
//   register is free or is being drained in the same cycle. The AND result
//   appears one cycle later in a registered response slot with a
//   valid/ready handshake.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   req        per-requester request (held until granted)
//   opnd       3 operand bits per requester; requester i owns opnd[3i+2:3i]
//   gnt        one-hot grant, combinational
//   rsp_valid  response slot holds a result
//   rsp_ready  consumer accepts the response
//   rsp_id     index of the requester the result belongs to
//   rsp_data   AND of the served requester's operand bits
//   op_count   total grants issued, modulo 256
// -----------------------------------------------------------------------------
module and3_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] opnd,
   output logic [NREQ-1:0]   gnt,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_data,
   output logic [7:0]        op_count
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          state_reg, state_next;
   logic [IDW-1:0]  rr_ptr_reg;
   logic            rsp_valid_reg;
   logic [IDW-1:0]  rsp_id_reg;
   logic            rsp_data_reg;
   logic [7:0]      op_count_reg;

   logic [NREQ-1:0] and_bits;
   logic            can_issue;
   logic            gnt_any;
   logic [IDW-1:0]  gnt_idx;

   // Per-requester AND of its three operand bits; the grant picks one.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_and
         assign and_bits[gi] = &opnd[3*gi +: 3];
      end
   endgenerate

   // The slot is free when idle, or when its current content leaves this cycle.
   assign can_issue = (state_reg == IDLE) | (rsp_valid_reg & rsp_ready);

   // Round-robin search starting at rr_ptr_reg. Walking from the farthest
   // candidate down to the nearest lets the nearest match win without a break.
   // Index arithmetic wraps naturally because NREQ is a power of two.
   always_comb begin
      logic [IDW-1:0] cand;
      cand    = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = rr_ptr_reg + IDW'(k);
         if (req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      // Reset is asynchronous, so the grant is masked directly as well.
      if (!can_issue || rst) begin
         gnt_any = 1'b0;
      end
   end

   assign gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

   // Next-state logic: a grant always (re)fills the slot; otherwise a
   // completed handshake empties it.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (gnt_any) state_next = HOLD;
         HOLD: begin
            if (gnt_any)        state_next = HOLD;
            else if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_data_reg  <= 1'b0;
         op_count_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         rsp_valid_reg <= (state_next == HOLD);
         if (gnt_any) begin
            rsp_id_reg   <= gnt_idx;
            rsp_data_reg <= and_bits[gnt_idx];
            rr_ptr_reg   <= gnt_idx + IDW'(1);
            op_count_reg <= op_count_reg + 8'd1;
         end
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_data  = rsp_data_reg;
   assign op_count  = op_count_reg;

endmodule

// File: tb/tb_and3_arbiter.sv
// -----------------------------------------------------------------------------
// tb_and3_arbiter
//   Self-checking bench for and3_arbiter. A behavioural model tracks the
//   response slot, the round-robin pointer and the grant counter; each test
//   task drives stimulus and compares the DUT against the model or against
//   fixed expected values.
// -----------------------------------------------------------------------------
module tb_and3_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] opnd;
   logic [3:0]  gnt;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic        rsp_data;
   logic [7:0]  op_count;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit m_valid;
   int m_ptr;
   int m_id;
   bit m_data;
   int m_count;

   and3_arbiter #(.NREQ(4), .IDW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .opnd      (opnd),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Index of the requester served this cycle, or -1: nearest requester at
   // or after the pointer, counted as a circular distance.
   function automatic int model_grant();
      int best;
      int best_dist;
      best      = -1;
      best_dist = 4;
      if (m_valid && !rsp_ready) return -1;
      for (int i = 0; i < 4; i++) begin
         if (req[i] && ((i - m_ptr + 4) % 4) < best_dist) begin
            best      = i;
            best_dist = (i - m_ptr + 4) % 4;
         end
      end
      return best;
   endfunction

   function automatic logic [3:0] model_gnt();
      int g;
      g = model_grant();
      return (g < 0) ? 4'b0000 : (4'b0001 << g);
   endfunction

   function automatic void model_reset();
      m_valid = 1'b0;
      m_ptr   = 0;
      m_id    = 0;
      m_data  = 1'b0;
      m_count = 0;
   endfunction

   // Advance one clock edge and update the model with the pre-edge inputs.
   task automatic tick();
      int g;
      logic [2:0] ops;
      g = model_grant();
      @(posedge clk);
      if (g >= 0) begin
         ops     = opnd[3*g +: 3];
         m_valid = 1'b1;
         m_id    = g;
         m_data  = &ops;
         m_ptr   = (g + 1) % 4;
         m_count = (m_count + 1) % 256;
      end else if (m_valid && rsp_ready) begin
         m_valid = 1'b0;
      end
      #1;
      $display("t=%0t req=%b rdy=%b gnt_idx=%0d -> valid=%b id=%0d data=%b cnt=%0d",
               $time, req, rsp_ready, g, rsp_valid, rsp_id, rsp_data, op_count);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      req = 4'b1111; opnd = '1; rsp_ready = 1'b1; rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin
         errors++; $display("FAIL reset_gnt got=%b want=0000", gnt);
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, op_count} !== 12'd0) begin
         errors++;
         $display("FAIL reset_outputs got valid=%b id=%0d data=%b cnt=%0d want all zero",
                  rsp_valid, rsp_id, rsp_data, op_count);
      end
      @(posedge clk); #1;
      rst = 1'b0; req = 4'b0000;
      model_reset();
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0010; opnd = 12'b000_000_111_000; rsp_ready = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
         errors++; $display("FAIL single_gnt got=%b want=0010", gnt);
      end
      tick();
      req = 4'b0000;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 1'b1 || op_count !== 8'd1) begin
         errors++;
         $display("FAIL single_rsp got valid=%b id=%0d data=%b cnt=%0d want 1/1/1/1",
                  rsp_valid, rsp_id, rsp_data, op_count);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL single_drain got valid=%b want=0", rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      req = 4'b1111; opnd = 12'b111_000_111_000; rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (gnt !== exp_g[c]) begin
            errors++; $display("FAIL rr_gnt[%0d] got=%b want=%b", c, gnt, exp_g[c]);
         end
         tick();
         checks++;
         if (rsp_id !== 2'(c % 4) || rsp_valid !== 1'b1 || rsp_data !== (c % 2 == 1)) begin
            errors++;
            $display("FAIL rr_rsp[%0d] got id=%0d valid=%b data=%b want id=%0d valid=1 data=%0d",
                     c, rsp_id, rsp_valid, rsp_data, c % 4, (c % 2 == 1));
         end
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      req = 4'b0001; opnd = 12'b000_000_000_011; rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (gnt !== 4'b0000) begin
            errors++; $display("FAIL bp_gnt[%0d] got=%b want=0000", c, gnt);
         end
         tick();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 1'b0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_hold[%0d] got valid=%b data=%b id=%0d want 1/0/0",
                     c, rsp_valid, rsp_data, rsp_id);
         end
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
         errors++; $display("FAIL bp_release_gnt got=%b want=0001", gnt);
      end
      tick();
      req = 4'b0000;
      tick();
   endtask

   task automatic test_wrap_and_hold();
      do_reset();
      req = 4'b1111; opnd = '0; rsp_ready = 1'b1;
      for (int c = 0; c < 256; c++) tick();
      checks++;
      if (op_count !== 8'd0) begin
         errors++; $display("FAIL wrap_count got=%0d want=0", op_count);
      end
      tick();   // one more grant moves the pointer to 1
      req = 4'b0000;
      for (int c = 0; c < 3; c++) tick();
      req = 4'b1111;
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
         errors++; $display("FAIL ptr_hold_gnt got=%b want=0010", gnt);
      end
      tick();
      checks++;
      if (op_count !== 8'd2 || rsp_id !== 2'd1) begin
         errors++; $display("FAIL ptr_hold_rsp got cnt=%0d id=%0d want 2/1", op_count, rsp_id);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req       = 4'($urandom_range(0, 15));
         opnd      = 12'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         checks++;
         if (gnt !== model_gnt()) begin
            errors++; $display("FAIL rand_gnt[%0d] got=%b want=%b", c, gnt, model_gnt());
         end
         tick();
         checks++;
         if (rsp_valid !== m_valid || rsp_id !== 2'(m_id) || rsp_data !== m_data ||
             op_count !== 8'(m_count)) begin
            errors++;
            $display("FAIL rand_rsp[%0d] got valid=%b id=%0d data=%b cnt=%0d want %b/%0d/%b/%0d",
                     c, rsp_valid, rsp_id, rsp_data, op_count, m_valid, m_id, m_data, m_count);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0100; opnd = '1; rsp_ready = 1'b0;
      tick();
      req = 4'b0000;
      #1;
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++; $display("FAIL areset_pre got valid=%b want=1", rsp_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || op_count !== 8'd0 || gnt !== 4'b0000) begin
         errors++;
         $display("FAIL areset_now got valid=%b cnt=%0d gnt=%b want 0/0/0000",
                  rsp_valid, op_count, gnt);
      end
      rst = 1'b0;
      model_reset();
      req = 4'b1010; rsp_ready = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
         errors++; $display("FAIL areset_first_gnt got=%b want=0010", gnt);
      end
      tick();
      checks++;
      if (rsp_id !== 2'd1 || op_count !== 8'd1) begin
         errors++; $display("FAIL areset_rsp got id=%0d cnt=%0d want 1/1", rsp_id, op_count);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap_and_hold();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/and3_arbiter.md
AND3_ARBITER -- requirements
Module: and3_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing the single 3-input AND unit; fixed at 4 for this release.
REQ-002 Parameter: IDW, default 2, width of requester index; SHALL equal clog2(NREQ).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  NREQ  per-requester request; requester i holds req[i] high until granted.
REQ-006 Port: opnd  input  3*NREQ  operands; requester i owns opnd[3i+2:3i], held stable while req[i] high.
REQ-007 Port: gnt  output  NREQ  one-hot grant, combinational; gnt[i] high for exactly the one cycle requester i is served.
REQ-008 Port: rsp_valid  output  1  registered; response holds a valid result.
REQ-009 Port: rsp_ready  input  1  consumer accepts response when rsp_valid & rsp_ready.
REQ-010 Port: rsp_id  output  IDW  registered; index of the requester the result belongs to.
REQ-011 Port: rsp_data  output  1  registered; AND of the served requester's 3 operand bits.
REQ-012 Port: op_count  output  8  registered; total grants issued, modulo 256.

Function
REQ-013 The block SHALL contain one FSM with states IDLE (no response pending) and HOLD (response pending).
REQ-014 Issue condition: `can_issue = (state==IDLE) | (rsp_valid & rsp_ready)`; no grant SHALL be asserted while can_issue is low.
REQ-015 When can_issue is high and req is non-zero, gnt SHALL select the first set req bit at or after rr_ptr, searching upward with wrap from NREQ-1 to 0.
REQ-016 gnt SHALL be all-zero when req is zero or can_issue is low; at most one gnt bit high in any cycle.
REQ-017 On a grant to i, the next edge SHALL load rsp_data = opnd[3i] & opnd[3i+1] & opnd[3i+2] and rsp_id = i, set rsp_valid, and enter HOLD.
REQ-018 Issue-to-response latency SHALL be exactly 1 cycle.
REQ-019 On a grant to i, the next edge SHALL set rr_ptr = (i+1) mod NREQ; with no grant, rr_ptr SHALL hold.
REQ-020 HOLD with rsp_ready low: rsp_valid, rsp_id and rsp_data SHALL hold unchanged.
REQ-021 HOLD with rsp_ready high and a grant in the same cycle: the new result SHALL replace the old one; rsp_valid stays high and the state stays HOLD, giving back-to-back throughput of 1 op/cycle.
REQ-022 HOLD with rsp_ready high and no grant: rsp_valid SHALL clear and the state SHALL return to IDLE.
REQ-023 op_count SHALL increment by 1 on every grant edge and wrap from 255 to 0.
REQ-024 A requester dropping req before being granted SHALL simply not be served; no error is flagged.

Reset
REQ-025 While rst is high, the following SHALL hold immediately, independent of clk: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, op_count=0.
REQ-026 gnt SHALL be all-zero while rst is high.
REQ-027 Reset asserted mid-operation SHALL discard any pending response without a handshake.
REQ-028 The first grant after reset release SHALL use priority order 0,1,2,3.

Verification
REQ-029 Single request: req=0010, opnd[5:3]=111, rsp_ready=1.
  - gnt=0010 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_id=1, rsp_data=1, op_count=1.
REQ-030 Round robin: req=1111 held, rsp_ready=1.
  - Grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
  - rsp_id sequence 0,1,2,3,0.
REQ-031 Backpressure: req=0001 held with opnd[2:0]=011 and rsp_ready=0 after the first grant.
  - rsp_valid=1, rsp_data=0 held for 5 cycles.
  - gnt=0000 throughout.
  - Raising rsp_ready produces a grant in that cycle.
REQ-032 Wrap and pointer hold:
  - 256 grants: op_count wraps to 0.
  - Idle cycles with req=0: rr_ptr unchanged, so the next grant follows the pointer.
REQ-033 Async reset: assert rst between clock edges while in HOLD with rsp_valid=1.
  - rsp_valid=0 and op_count=0 immediately, before the next edge.
  - After release, req=1010 grants 0010 first.
